// File: rtl/multicycle_datapath.sv
// Multi-cycle RV32I/RV32E core sharing one valid/ready memory port for fetch and data.
// Define MULTICYCLE_DATAPATH_PERF_EN to add the cycle_count/instret_count outputs.
module multicycle_datapath #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned REG_COUNT = 32
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc_out,
  output logic        instr_retired,
  output logic        halted,
  output logic [1:0]  halt_cause
`ifdef MULTICYCLE_DATAPATH_PERF_EN
  ,
  output logic [63:0] cycle_count,
  output logic [63:0] instret_count
`endif
);
  localparam int unsigned RAW = $clog2(REG_COUNT);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_HALT} state_e;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLTU} alu_op_e;
  typedef enum logic [2:0] {K_ALU_R, K_ALU_I, K_LOAD, K_STORE, K_BEQ, K_BNE, K_JAL, K_JALR} kind_e;

  state_e      state_q;
  alu_op_e     op_q, op_d;
  kind_e       kind_q, kind_d;
  logic [31:0] pc_q, ir_q, a_q, b_q, imm_q, imm_d, alu_q, alu_d, target_q, target_d, mdr_q;
  logic [4:0]  rd_q;
  logic [29:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        mem_req_q, mem_we_q, retired_q, halted_q;
  logic [1:0]  cause_q;
  logic [31:0] rf_q [REG_COUNT];

  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [4:0]  rs1, rs2, rd;
  logic        legal_d, use_rs1, use_rs2, use_rd, taken_d;
  logic [31:0] rs1_val, rs2_val, opb, pc4, wb_data, wb_pc;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign f3     = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign f7     = ir_q[31:25];

  always_comb begin
    legal_d = 1'b1;
    kind_d  = K_ALU_R;
    op_d    = OP_ADD;
    imm_d   = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    case (opcode)
      7'b0110011: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
        case ({f7, f3})
          {7'h00, 3'b000}: op_d = OP_ADD;
          {7'h20, 3'b000}: op_d = OP_SUB;
          {7'h00, 3'b111}: op_d = OP_AND;
          {7'h00, 3'b110}: op_d = OP_OR;
          {7'h00, 3'b100}: op_d = OP_XOR;
          {7'h00, 3'b010}: op_d = OP_SLT;
          {7'h00, 3'b011}: op_d = OP_SLTU;
          default:         legal_d = 1'b0;
        endcase
      end
      7'b0010011: begin
        kind_d = K_ALU_I; use_rs1 = 1'b1; use_rd = 1'b1;
        imm_d  = {{20{ir_q[31]}}, ir_q[31:20]};
        case (f3)
          3'b000:  op_d = OP_ADD;
          3'b111:  op_d = OP_AND;
          3'b110:  op_d = OP_OR;
          3'b100:  op_d = OP_XOR;
          3'b010:  op_d = OP_SLT;
          3'b011:  op_d = OP_SLTU;
          default: legal_d = 1'b0;
        endcase
      end
      7'b0000011: begin
        kind_d = K_LOAD; use_rs1 = 1'b1; use_rd = 1'b1;
        imm_d  = {{20{ir_q[31]}}, ir_q[31:20]};
        legal_d = (f3 == 3'b010);
      end
      7'b0100011: begin
        kind_d = K_STORE; use_rs1 = 1'b1; use_rs2 = 1'b1;
        imm_d  = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
        legal_d = (f3 == 3'b010);
      end
      7'b1100011: begin
        kind_d = (f3 == 3'b001) ? K_BNE : K_BEQ;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        imm_d  = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
        legal_d = (f3 == 3'b000) || (f3 == 3'b001);
      end
      7'b1101111: begin
        kind_d = K_JAL; use_rd = 1'b1;
        imm_d  = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
      end
      7'b1100111: begin
        kind_d = K_JALR; use_rs1 = 1'b1; use_rd = 1'b1;
        imm_d  = {{20{ir_q[31]}}, ir_q[31:20]};
        legal_d = (f3 == 3'b000);
      end
      default: legal_d = 1'b0;
    endcase
    // Only fields the format actually uses are range-checked (RV32E)
    if ((use_rs1 && 32'(rs1) >= REG_COUNT) || (use_rs2 && 32'(rs2) >= REG_COUNT) ||
        (use_rd && 32'(rd) >= REG_COUNT))
      legal_d = 1'b0;
  end

  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != 5'd0 && 32'(rs1) < REG_COUNT) rs1_val = rf_q[rs1[RAW-1:0]];
    if (rs2 != 5'd0 && 32'(rs2) < REG_COUNT) rs2_val = rf_q[rs2[RAW-1:0]];
  end

  always_comb begin
    opb = (kind_q == K_ALU_R) ? b_q : imm_q;
    case (op_q)
      OP_SUB:  alu_d = a_q - opb;
      OP_AND:  alu_d = a_q & opb;
      OP_OR:   alu_d = a_q | opb;
      OP_XOR:  alu_d = a_q ^ opb;
      OP_SLT:  alu_d = {31'd0, $signed(a_q) < $signed(opb)};
      OP_SLTU: alu_d = {31'd0, a_q < opb};
      default: alu_d = a_q + opb;
    endcase
    pc4      = pc_q + 32'd4;
    target_d = (kind_q == K_JALR) ? ((a_q + imm_q) & ~32'd1) : (pc_q + imm_q);
    case (kind_q)
      K_BEQ:          taken_d = (a_q == b_q);
      K_BNE:          taken_d = (a_q != b_q);
      K_JAL, K_JALR:  taken_d = 1'b1;
      default:        taken_d = 1'b0;
    endcase
    wb_data = (kind_q == K_LOAD) ? mdr_q :
              (kind_q == K_JAL || kind_q == K_JALR) ? pc4 : alu_q;
    wb_pc   = (kind_q == K_JAL || kind_q == K_JALR) ? target_q : pc4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      imm_q       <= '0;
      alu_q       <= '0;
      target_q    <= '0;
      mdr_q       <= '0;
      rd_q        <= '0;
      op_q        <= OP_ADD;
      kind_q      <= K_ALU_R;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= RESET_PC[31:2];
      mem_wdata_q <= '0;
      retired_q   <= 1'b0;
      halted_q    <= 1'b0;
      cause_q     <= 2'b00;
      for (int unsigned i = 0; i < REG_COUNT; i++) rf_q[i] <= '0;
    end else begin
      retired_q <= 1'b0;
      case (state_q)
        S_FETCH: begin
          // First cycle after reset issues the request; later fetches arrive with it already raised
          if (!mem_req_q) begin
            mem_req_q  <= 1'b1;
            mem_addr_q <= pc_q[31:2];
          end else if (mem_ready) begin
            ir_q      <= mem_rdata;
            mem_req_q <= 1'b0;
            state_q   <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (!legal_d) begin
            halted_q <= 1'b1;
            cause_q  <= 2'b01;
            state_q  <= S_HALT;
          end else begin
            a_q     <= rs1_val;
            b_q     <= rs2_val;
            imm_q   <= imm_d;
            op_q    <= op_d;
            kind_q  <= kind_d;
            rd_q    <= rd;
            state_q <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          if (taken_d && target_d[1:0] != 2'b00) begin
            halted_q <= 1'b1;
            cause_q  <= 2'b11;
            state_q  <= S_HALT;
          end else if (kind_q == K_BEQ || kind_q == K_BNE) begin
            pc_q       <= taken_d ? target_d : pc4;
            mem_addr_q <= taken_d ? target_d[31:2] : pc4[31:2];
            mem_req_q  <= 1'b1;
            retired_q  <= 1'b1;
            state_q    <= S_FETCH;
          end else if (kind_q == K_LOAD || kind_q == K_STORE) begin
            if (alu_d[1:0] != 2'b00) begin
              halted_q <= 1'b1;
              cause_q  <= 2'b10;
              state_q  <= S_HALT;
            end else begin
              mem_req_q   <= 1'b1;
              mem_we_q    <= (kind_q == K_STORE);
              mem_addr_q  <= alu_d[31:2];
              mem_wdata_q <= b_q;
              state_q     <= S_MEMORY;
            end
          end else begin
            alu_q    <= alu_d;
            target_q <= target_d;
            state_q  <= S_WRITEBACK;
          end
        end
        S_MEMORY: begin
          if (mem_ready) begin
            mem_we_q <= 1'b0;
            if (kind_q == K_STORE) begin
              pc_q       <= pc4;
              mem_addr_q <= pc4[31:2];
              retired_q  <= 1'b1;
              state_q    <= S_FETCH;
            end else begin
              mem_req_q <= 1'b0;
              mdr_q     <= mem_rdata;
              state_q   <= S_WRITEBACK;
            end
          end
        end
        S_WRITEBACK: begin
          if (rd_q != 5'd0) rf_q[rd_q[RAW-1:0]] <= wb_data;
          pc_q       <= wb_pc;
          mem_addr_q <= wb_pc[31:2];
          mem_req_q  <= 1'b1;
          retired_q  <= 1'b1;
          state_q    <= S_FETCH;
        end
        default: ;
      endcase
    end
  end

  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = {mem_addr_q, 2'b00};
  assign mem_wdata     = mem_wdata_q;
  assign pc_out        = pc_q;
  assign instr_retired = retired_q;
  assign halted        = halted_q;
  assign halt_cause    = cause_q;

`ifdef MULTICYCLE_DATAPATH_PERF_EN
  logic [63:0] cycle_q, instret_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q <= cycle_q + 64'd1;
      if (retired_q) instret_q <= instret_q + 64'd1;
    end
  end
  assign cycle_count   = cycle_q;
  assign instret_count = instret_q;
`endif
endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath: programs in a word memory, checks retire timing, stores and halts.
module tb_multicycle_datapath;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_we, mem_ready, instr_retired, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;
  logic [1:0]  halt_cause;
  logic [31:0] mem [0:255];
  logic        ready_en = 1'b1;
  logic [31:0] st_addr = '0, st_data = '0;
  int          compared = 0, mismatched = 0;

  logic        req16, we16, ret16, halted16;
  logic [31:0] addr16, wdata16, pc16;
  logic [1:0]  cause16;
  logic [31:0] rdata16 = 32'h0000_0013;

`ifdef MULTICYCLE_DATAPATH_PERF_EN
  logic [63:0] cyc, inst, cyc16, inst16;
`endif

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];
  assign mem_ready = mem_req && ready_en;

  always @(posedge clk)
    if (mem_req && mem_we && mem_ready) begin
      st_addr <= mem_addr;
      st_data <= mem_wdata;
    end

  multicycle_datapath dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc_out(pc_out),
    .instr_retired(instr_retired), .halted(halted), .halt_cause(halt_cause)
`ifdef MULTICYCLE_DATAPATH_PERF_EN
    , .cycle_count(cyc), .instret_count(inst)
`endif
  );

  multicycle_datapath #(.RESET_PC(32'h0000_0100), .REG_COUNT(16)) dut16 (
    .clk(clk), .rst(rst), .mem_req(req16), .mem_we(we16), .mem_addr(addr16),
    .mem_wdata(wdata16), .mem_rdata(rdata16), .mem_ready(req16), .pc_out(pc16),
    .instr_retired(ret16), .halted(halted16), .halt_cause(cause16)
`ifdef MULTICYCLE_DATAPATH_PERF_EN
    , .cycle_count(cyc16), .instret_count(inst16)
`endif
  );

  task automatic fill();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_007F;
  endtask

  task automatic do_reset();
    ready_en = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_retire(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!instr_retired && n < max);
    compared++;
    if (!instr_retired) begin
      mismatched++;
      $display("FAIL retire_timeout: no instr_retired within %0d cycles (pc_out %h)", max, pc_out);
    end
  endtask

  task automatic test_add_program();
    int n;
    fill();
    mem[0] = 32'h0050_0093;  // addi x1,x0,5
    mem[1] = 32'hFFD0_0113;  // addi x2,x0,-3
    mem[2] = 32'h0020_81B3;  // add x3,x1,x2
    mem[3] = 32'h2030_2023;  // sw x3,0x200(x0)
    do_reset();
    wait_retire(20, n);
    for (int k = 0; k < 3; k++) begin
      wait_retire(20, n);
      compared++;
      if (n !== 4) begin mismatched++; $display("FAIL add_prog_spacing[%0d]: got %0d want 4", k, n); end
      if (k == 1) begin
        compared++;
        if (pc_out !== 32'h0000_000C) begin mismatched++; $display("FAIL add_prog_pc: got %h want 0000000c", pc_out); end
      end
    end
    compared++;
    if (st_addr !== 32'h200 || st_data !== 32'd2)
      begin mismatched++; $display("FAIL add_prog_x3: got %h@%h want 00000002@00000200", st_data, st_addr); end
  endtask

  task automatic test_alu_ops();
    int n;
    logic [31:0] exp [0:5] = '{32'd1, 32'd0, 32'd8, 32'hFFFF_FFF8, 32'd1, 32'h0000_00F0};
    fill();
    mem[0]  = 32'h0050_0093;  // addi x1,x0,5
    mem[1]  = 32'hFFD0_0113;  // addi x2,x0,-3
    mem[2]  = 32'h0011_2233;  // slt  x4,x2,x1
    mem[3]  = 32'h0011_32B3;  // sltu x5,x2,x1
    mem[4]  = 32'h4020_8333;  // sub  x6,x1,x2
    mem[5]  = 32'h0020_C3B3;  // xor  x7,x1,x2
    mem[6]  = 32'hFFF0_B413;  // sltiu x8,x1,-1
    mem[7]  = 32'h0F01_7493;  // andi x9,x2,0xF0
    mem[8]  = 32'h0020_9463;  // bne x1,x2,+8
    for (int k = 0; k < 6; k++) mem[10+k] = 32'h3000_2023 | (32'(k + 4) << 20);  // sw x(4+k),0x300(x0)
    do_reset();
    for (int k = 0; k < 8; k++) wait_retire(20, n);
    wait_retire(20, n);
    compared++;
    if (n !== 3 || pc_out !== 32'h28)
      begin mismatched++; $display("FAIL bne_taken: got %0d cycles pc %h want 3 cycles pc 00000028", n, pc_out); end
    for (int k = 0; k < 6; k++) begin
      wait_retire(20, n);
      compared++;
      if (n !== 4 || st_addr !== 32'h300 || st_data !== exp[k])
        begin mismatched++; $display("FAIL alu_store[%0d]: got %h@%h (%0d cycles) want %h@00000300 (4 cycles)", k, st_data, st_addr, n, exp[k]); end
    end
  endtask

  task automatic test_lw_stall();
    int n, hits, stalls, bad;
    fill();
    mem[0]     = 32'h0000_0013;  // nop
    mem[1]     = 32'h1000_2283;  // lw x5,0x100(x0)
    mem[2]     = 32'h2050_2223;  // sw x5,0x204(x0)
    mem[32'h40] = 32'hDEAD_BEEF;
    do_reset();
    wait_retire(20, n);
    n = 0; hits = 0; stalls = 0; bad = 0;
    do begin
      @(negedge clk);
      n++;
      if (mem_req && mem_addr == 32'h100) begin
        hits++;
        if (mem_we) bad++;
        if (stalls < 3) begin ready_en = 1'b0; stalls++; end
        else ready_en = 1'b1;
      end
    end while (!instr_retired && n < 30);
    ready_en = 1'b1;
    compared++;
    if (n !== 8) begin mismatched++; $display("FAIL lw_stall_latency: got %0d want 8", n); end
    compared++;
    if (hits !== 4 || bad !== 0)
      begin mismatched++; $display("FAIL lw_stall_hold: got %0d req cycles (%0d with we) want 4 (0)", hits, bad); end
    wait_retire(20, n);
    compared++;
    if (st_addr !== 32'h204 || st_data !== 32'hDEAD_BEEF)
      begin mismatched++; $display("FAIL lw_data: got %h@%h want deadbeef@00000204", st_data, st_addr); end
  endtask

  task automatic test_branch();
    int n;
    fill();
    mem[0] = 32'h0200_006F;  // jal x0,+32
    mem[8] = 32'hFE00_0CE3;  // beq x0,x0,-8 at 0x20
    mem[6] = 32'h2000_2423;  // sw x0,0x208(x0) at 0x18
    do_reset();
    wait_retire(20, n);
    compared++;
    if (pc_out !== 32'h20) begin mismatched++; $display("FAIL jal_target: got %h want 00000020", pc_out); end
    wait_retire(20, n);
    compared++;
    if (n !== 3 || pc_out !== 32'h18)
      begin mismatched++; $display("FAIL beq_back: got %0d cycles pc %h want 3 cycles pc 00000018", n, pc_out); end
    wait_retire(20, n);
    compared++;
    if (st_addr !== 32'h208 || st_data !== 32'd0)
      begin mismatched++; $display("FAIL x0_after_jal: got %h@%h want 00000000@00000208", st_data, st_addr); end
  endtask

  task automatic test_jalr();
    int n;
    fill();
    mem[0]  = 32'h0410_0113;  // addi x2,x0,0x41
    mem[1]  = 32'h0001_00E7;  // jalr x1,x2,0
    mem[16] = 32'h2010_2623;  // sw x1,0x20C(x0) at 0x40
    do_reset();
    wait_retire(20, n);
    wait_retire(20, n);
    compared++;
    if (n !== 4 || pc_out !== 32'h40)
      begin mismatched++; $display("FAIL jalr_target: got %0d cycles pc %h want 4 cycles pc 00000040", n, pc_out); end
    wait_retire(20, n);
    compared++;
    if (st_addr !== 32'h20C || st_data !== 32'h8)
      begin mismatched++; $display("FAIL jalr_link: got %h@%h want 00000008@0000020c", st_data, st_addr); end
  endtask

  task automatic test_halts();
    int rets;
    logic [31:0] ins [0:4] = '{32'h0000_007F, 32'h0020_2083, 32'h0020_00E7, 32'h0220_81B3, 32'h0010_9093};
    logic [1:0]  cause [0:4] = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b01};
    for (int k = 0; k < 5; k++) begin
      fill();
      mem[0] = 32'h0000_0013;
      mem[1] = ins[k];
      do_reset();
      rets = 0;
      repeat (14) begin
        @(negedge clk);
        if (instr_retired) rets++;
      end
      compared++;
      if (rets !== 1 || halted !== 1'b1 || halt_cause !== cause[k] || mem_req !== 1'b0 || pc_out !== 32'h4)
        begin
          mismatched++;
          $display("FAIL halt[%0d]: got retires=%0d halted=%b cause=%b req=%b pc=%h want 1 1 %b 0 00000004",
                   k, rets, halted, halt_cause, mem_req, pc_out, cause[k]);
        end
    end
  endtask

  task automatic test_reset();
    compared++;
    if (halted !== 1'b1) begin mismatched++; $display("FAIL pre_reset_halted: got %b want 1", halted); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    compared++;
    if (pc_out !== 32'h0 || mem_req !== 1'b0 || mem_we !== 1'b0 || instr_retired !== 1'b0 ||
        halted !== 1'b0 || halt_cause !== 2'b00)
      begin
        mismatched++;
        $display("FAIL reset_state: got pc=%h req=%b we=%b ret=%b halted=%b cause=%b want 0 0 0 0 0 00",
                 pc_out, mem_req, mem_we, instr_retired, halted, halt_cause);
      end
    compared++;
    if (pc16 !== 32'h100 || req16 !== 1'b0)
      begin mismatched++; $display("FAIL reset_pc_param: got pc=%h req=%b want 00000100 0", pc16, req16); end
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    int n;
    fill();
    for (int i = 0; i < 4; i++) mem[i] = 32'h0000_0013;
    do_reset();
    wait_retire(20, n);
    ready_en = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h4)
      begin mismatched++; $display("FAIL fetch_wait_hold: got req=%b addr=%h want 1 00000004", mem_req, mem_addr); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ready_en = 1'b1;
    compared++;
    if (pc_out !== 32'h0 || mem_req !== 1'b0 || halted !== 1'b0 || instr_retired !== 1'b0)
      begin mismatched++; $display("FAIL reset_mid_fetch: got pc=%h req=%b halted=%b ret=%b want 0 0 0 0", pc_out, mem_req, halted, instr_retired); end
    wait_retire(20, n);
    compared++;
    if (pc_out !== 32'h4) begin mismatched++; $display("FAIL restart_after_reset: got pc %h want 00000004", pc_out); end
  endtask

  task automatic test_regcount16();
    int rets;
    logic [31:0] bad [0:1] = '{32'h0020_88B3, 32'h0028_00B3};  // add x17,x1,x2 ; add x1,x16,x2
    rdata16 = 32'h0020_87B3;  // add x15,x1,x2
    do_reset();
    rets = 0;
    repeat (20) begin
      @(negedge clk);
      if (ret16) rets++;
    end
    compared++;
    if (rets !== 4 || halted16 !== 1'b0)
      begin mismatched++; $display("FAIL rv32e_x15: got retires=%0d halted=%b want 4 0", rets, halted16); end
    for (int k = 0; k < 2; k++) begin
      rdata16 = bad[k];
      do_reset();
      repeat (10) @(negedge clk);
      compared++;
      if (halted16 !== 1'b1 || cause16 !== 2'b01 || req16 !== 1'b0 || pc16 !== 32'h100)
        begin mismatched++; $display("FAIL rv32e_range[%0d]: got halted=%b cause=%b req=%b pc=%h want 1 01 0 00000100", k, halted16, cause16, req16, pc16); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_add_program();
    test_alu_ops();
    test_lw_stall();
    test_branch();
    test_jalr();
    test_halts();
    test_reset();
    test_reset_mid_fetch();
    test_regcount16();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
